// File: rtl/nn_layer_pkg.sv
// nn_layer_pkg
// Shared definitions for the time-multiplexed binary-input neuron layer.
//   - default layer geometry (used as parameter defaults by neuron_layer_sched)
//   - configuration word width / field offsets and the cfg_word_t struct
//   - scheduler FSM state enum
// Config word layout, MSB to LSB: bw | bias | weights[N_INPUTS-1:0].
// Weight i sits at [i*WEIGHT_BITS +: WEIGHT_BITS].
package nn_layer_pkg;

    localparam int N_INPUTS_DEF    = 4;
    localparam int WEIGHT_BITS_DEF = 3;
    localparam int INPUT_BITS_DEF  = 1;
    localparam int SUM_BITS_DEF    = 7;
    localparam int H_DEF           = 6;
    localparam int N_NEURONS_DEF   = 8;

    // Width of a config word for an arbitrary geometry.
    function automatic int cfg_width(input int n_inputs, input int weight_bits,
                                     input int sum_bits, input int input_bits);
        return n_inputs * weight_bits + weight_bits + sum_bits - input_bits;
    endfunction

    // Field offsets / widths for the default geometry.
    localparam int BW_BITS     = SUM_BITS_DEF - INPUT_BITS_DEF;
    localparam int WEIGHTS_LSB = 0;
    localparam int BIAS_LSB    = N_INPUTS_DEF * WEIGHT_BITS_DEF;
    localparam int BW_LSB      = BIAS_LSB + WEIGHT_BITS_DEF;
    localparam int CFG_W       = BW_LSB + BW_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [BW_BITS-1:0]                              bw;
        logic [WEIGHT_BITS_DEF-1:0]                      bias;
        logic [N_INPUTS_DEF-1:0][WEIGHT_BITS_DEF-1:0]    weights;
    } cfg_word_t;

endpackage

// File: rtl/wallace_tree.sv
// wallace_tree
// Signed neuron adder: sum = sum_i sext(multiplicants[i]) + sext(bias)
//                          + zext(baugh_wooley), wrapping modulo 2^SUM_BITS.
// Rows are reduced with 3:2 carry-save compressors, one row per level, for
// at most h levels; the final two rows go through one carry-propagate adder.
// h must be at least N_INPUTS (N_INPUTS+2 rows need N_INPUTS levels).
// Ports:
//   multiplicants [N_INPUTS*WEIGHT_BITS] in : gated signed partial products
//   bias          [WEIGHT_BITS]          in : signed bias
//   baugh_wooley  [BW_BITS]              in : unsigned correction constant
//   sum           [SUM_BITS]             out: wrapped two's complement sum
module wallace_tree #(
    parameter int N_INPUTS    = 4,
    parameter int WEIGHT_BITS = 3,
    parameter int SUM_BITS    = 7,
    parameter int BW_BITS     = 6,
    parameter int h           = 6
) (
    input  logic [N_INPUTS*WEIGHT_BITS-1:0] multiplicants,
    input  logic [WEIGHT_BITS-1:0]          bias,
    input  logic [BW_BITS-1:0]              baugh_wooley,
    output logic [SUM_BITS-1:0]             sum
);

    localparam int ROWS = N_INPUTS + 2;

    logic [SUM_BITS-1:0] rows [ROWS];
    logic [SUM_BITS-1:0] s3, c3;
    int                  live;

    always_comb begin
        s3   = '0;
        c3   = '0;
        live = ROWS;
        rows[0] = {{(SUM_BITS-WEIGHT_BITS){bias[WEIGHT_BITS-1]}}, bias};
        rows[1] = {{(SUM_BITS-BW_BITS){1'b0}}, baugh_wooley};
        for (int i = 0; i < N_INPUTS; i++) begin
            rows[2+i] = {{(SUM_BITS-WEIGHT_BITS){multiplicants[i*WEIGHT_BITS+WEIGHT_BITS-1]}},
                         multiplicants[i*WEIGHT_BITS +: WEIGHT_BITS]};
        end
        for (int l = 0; l < h; l++) begin
            if (live > 2) begin
                s3 = rows[live-3] ^ rows[live-2] ^ rows[live-1];
                c3 = ((rows[live-3] & rows[live-2]) |
                      (rows[live-3] & rows[live-1]) |
                      (rows[live-2] & rows[live-1])) << 1;
                rows[live-3] = s3;
                rows[live-2] = c3;
                live = live - 1;
            end
        end
        sum = rows[0] + rows[1];
    end

endmodule

// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched
// Shares one wallace_tree across all neurons of a binary-input layer. Each
// accepted input vector is stepped through the neurons one per cycle; sums
// are registered, sign-activated and packed into out_vec.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cfg_we/cfg_addr/cfg_data   : config write (IDLE only, addr < N_NEURONS)
//   cfg_err                    : one-cycle pulse on a rejected write
//   in_valid/in_ready/in_vec   : input vector handshake
//   out_valid/out_ready/out_vec: layer result handshake, bit k = neuron k
//   out_sums                   : raw per-neuron sums (NEURON_LAYER_SCHED_SUM_OUT_EN only)
// Optional feature macro: NEURON_LAYER_SCHED_SUM_OUT_EN
module neuron_layer_sched
    import nn_layer_pkg::*;
#(
    parameter int N_INPUTS    = N_INPUTS_DEF,
    parameter int WEIGHT_BITS = WEIGHT_BITS_DEF,
    parameter int INPUT_BITS  = INPUT_BITS_DEF,
    parameter int SUM_BITS    = SUM_BITS_DEF,
    parameter int H           = H_DEF,
    parameter int N_NEURONS   = N_NEURONS_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0]           cfg_addr,
    input  logic [cfg_width(N_INPUTS, WEIGHT_BITS, SUM_BITS, INPUT_BITS)-1:0] cfg_data,
    output logic                                   cfg_err,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_INPUTS-1:0]                    in_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_NEURONS-1:0]                   out_vec
`ifdef NEURON_LAYER_SCHED_SUM_OUT_EN
    ,
    output logic [N_NEURONS*SUM_BITS-1:0]          out_sums
`endif
);

    localparam int IDX_W    = $clog2(N_NEURONS);
    localparam int CW       = cfg_width(N_INPUTS, WEIGHT_BITS, SUM_BITS, INPUT_BITS);
    localparam int BW_W     = SUM_BITS - INPUT_BITS;
    localparam int BIAS_OFS = N_INPUTS * WEIGHT_BITS;
    localparam int BW_OFS   = BIAS_OFS + WEIGHT_BITS;

    sched_state_t                    state, state_nxt;
    logic [N_NEURONS-1:0][CW-1:0]    cfg_q;
    logic [N_INPUTS-1:0]             in_vec_q;
    logic [IDX_W-1:0]                idx, idx_q;
    logic                            drain;
    logic [SUM_BITS-1:0]             sum, sum_q;
    logic                            issue, wb_vld, last_issue;
    logic                            in_fire, cfg_ok;
    logic [CW-1:0]                   cur_cfg;
    logic [N_INPUTS*WEIGHT_BITS-1:0] mult;

    assign in_fire    = in_valid && in_ready;
    assign cfg_ok     = cfg_we && (state == ST_IDLE) &&
                        ({1'b0, cfg_addr} < (IDX_W+1)'(N_NEURONS));
    // A neuron is issued to the tree every RUN cycle except the drain cycle.
    assign issue      = (state == ST_RUN) && !drain;
    assign last_issue = issue && (idx == IDX_W'(N_NEURONS-1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_fire)   state_nxt = ST_RUN;
            ST_RUN:  if (drain)     state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // ---------------- shared tree ----------------
    assign cur_cfg = cfg_q[idx];

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_pp
        assign mult[i*WEIGHT_BITS +: WEIGHT_BITS] =
            in_vec_q[i] ? cur_cfg[i*WEIGHT_BITS +: WEIGHT_BITS] : '0;
    end

    wallace_tree #(
        .N_INPUTS   (N_INPUTS),
        .WEIGHT_BITS(WEIGHT_BITS),
        .SUM_BITS   (SUM_BITS),
        .BW_BITS    (BW_W),
        .h          (H)
    ) u_tree (
        .multiplicants(mult),
        .bias         (cur_cfg[BIAS_OFS +: WEIGHT_BITS]),
        .baugh_wooley (cur_cfg[BW_OFS +: BW_W]),
        .sum          (sum)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            cfg_err  <= 1'b0;
            in_vec_q <= '0;
            idx      <= '0;
            idx_q    <= '0;
            drain    <= 1'b0;
            sum_q    <= '0;
            wb_vld   <= 1'b0;
            out_vec  <= '0;
        end else begin
            // Write commits even when a vector is accepted the same cycle,
            // so that vector sees the new word.
            if (cfg_ok) cfg_q[cfg_addr] <= cfg_data;
            cfg_err <= cfg_we && !cfg_ok;

            if (in_fire) begin
                in_vec_q <= in_vec;
                idx      <= '0;
            end else if (issue && !last_issue) begin
                idx <= idx + 1'b1;
            end

            // Drain lasts exactly one cycle: set after the last issue and
            // cleared on the next edge because issue is off while draining.
            drain  <= last_issue;
            sum_q  <= sum;
            idx_q  <= idx;
            wb_vld <= issue;
            if (wb_vld) out_vec[idx_q] <= ~sum_q[SUM_BITS-1];
        end
    end

`ifdef NEURON_LAYER_SCHED_SUM_OUT_EN
    logic [N_NEURONS-1:0][SUM_BITS-1:0] sums_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sums_q         <= '0;
        else if (wb_vld) sums_q[idx_q]  <= sum_q;
    end

    assign out_sums = sums_q;
`endif

endmodule

// File: tb/tb_neuron_layer_sched.sv
module tb_neuron_layer_sched;
    import nn_layer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default geometry)
    logic        rst_n, cfg_we, cfg_err, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  cfg_addr;
    logic [20:0] cfg_data;
    logic [3:0]  in_vec;
    logic [7:0]  out_vec;
    // second instance with 6 neurons: addresses 6 and 7 are out of range
    logic        b_cfg_we, b_cfg_err, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_cfg_addr;
    logic [20:0] b_cfg_data;
    logic [3:0]  b_in_vec;
    logic [5:0]  b_out_vec;
`ifdef NEURON_LAYER_SCHED_SUM_OUT_EN
    logic [55:0] out_sums;
    logic [41:0] b_out_sums;
`endif

    neuron_layer_sched dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid),
        .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec)
`ifdef NEURON_LAYER_SCHED_SUM_OUT_EN
        , .out_sums(out_sums)
`endif
    );

    neuron_layer_sched #(.N_NEURONS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
        .cfg_data(b_cfg_data), .cfg_err(b_cfg_err), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_vec(b_in_vec), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_vec(b_out_vec)
`ifdef NEURON_LAYER_SCHED_SUM_OUT_EN
        , .out_sums(b_out_sums)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    logic [20:0] m_cfg [8];
    logic [7:0]  sb_q [$];

    // Golden model: straight integer arithmetic per neuron, wrapped to 7 bits.
    function automatic logic [7:0] model(input logic [3:0] v);
        logic [7:0]        r;
        int                s;
        logic signed [2:0] w;
        logic [5:0]        bwv;
        logic [6:0]        t;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s = 0;
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    w = m_cfg[k][i*3 +: 3];
                    s += int'(w);
                end
            end
            w   = m_cfg[k][12 +: 3];
            s  += int'(w);
            bwv = m_cfg[k][15 +: 6];
            s  += int'(bwv);
            t   = 7'(s);
            r[k] = ~t[6];
        end
        return r;
    endfunction

    function automatic logic [20:0] mk_word(input logic [5:0] bw, input logic [2:0] bias,
                                            input logic [2:0] w);
        cfg_word_t c;
        c.bw   = bw;
        c.bias = bias;
        for (int i = 0; i < 4; i++) c.weights[i] = w;
        return c;
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [20:0] d, output logic err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic send_vec(input logic [3:0] v, output bit to);
        int n = 0;
        to = 1'b0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin to = 1'b1; return; end
        in_valid = 1'b1; in_vec = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect_vec(output logic [7:0] got, output bit to);
        int n = 0;
        to = 1'b0;
        got = '0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) begin to = 1'b1; return; end
        got = out_vec;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_vec !== 8'h00) begin failures++; $display("FAIL reset_out_vec got=%h exp=00", out_vec); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_latency_zero_cfg();
        bit to;
        logic [7:0] exp;
        sb_q.push_back(model(4'b1111));
        send_vec(4'b1111, to);
        checks++; if (to) begin failures++; $display("FAIL lat_accept timeout got=1 exp=0"); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_T9_valid got=%b exp=1", out_valid); end
        exp = sb_q.pop_front();
        checks++; if (out_vec !== exp) begin failures++; $display("FAIL lat_T9_vec got=%h exp=%h", out_vec, exp); end
        checks++; if (out_vec !== 8'hFF) begin failures++; $display("FAIL zero_cfg_vec got=%h exp=ff", out_vec); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_neuron3();
        bit to; logic err; logic [7:0] got, exp;
        m_cfg[3] = mk_word(6'd0, 3'd0, 3'b100);
        cfg_write(3'd3, m_cfg[3], err);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL n3_cfg_err got=%b exp=0", err); end
        sb_q.push_back(model(4'b1111));
        send_vec(4'b1111, to);
        collect_vec(got, to);
        checks++; if (to) begin failures++; $display("FAIL n3_timeout got=1 exp=0"); end
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL n3_model got=%h exp=%h", got, exp); end
        checks++; if (got !== 8'hF7) begin failures++; $display("FAIL n3_const got=%h exp=f7", got); end
    endtask

    task automatic test_random();
        bit to; logic err; logic [7:0] got, exp; logic [3:0] v;
        int bad = 0;
        for (int n = 0; n < 200; n++) begin
            if (n % 25 == 0) begin
                for (int k = 0; k < 8; k++) begin
                    m_cfg[k] = 21'($urandom);
                    cfg_write(3'(k), m_cfg[k], err);
                    if (err !== 1'b0) bad++;
                end
            end
            v = 4'($urandom);
            sb_q.push_back(model(v));
            send_vec(v, to);
            if (to) bad++;
            collect_vec(got, to);
            if (to) bad++;
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rand_vec n=%0d in=%b got=%h exp=%h", n, v, got, exp); end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_handshake got=%0d exp=0", bad); end
    endtask

    task automatic test_cfg_reject();
        bit to; logic err; logic [7:0] got, exp;
        m_cfg[2] = mk_word(6'd0, 3'd0, 3'b100);
        cfg_write(3'd2, m_cfg[2], err);
        sb_q.push_back(model(4'b1111));
        send_vec(4'b1111, to);
        cfg_write(3'd2, 21'd0, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rej_run_err got=%b exp=1", err); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rej_pulse_len got=%b exp=0", cfg_err); end
        collect_vec(got, to);
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL rej_vec got=%h exp=%h", got, exp); end
        sb_q.push_back(model(4'b1111));
        send_vec(4'b1111, to);
        collect_vec(got, to);
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL rej_rerun got=%h exp=%h", got, exp); end
        checks++; if (got[2] !== 1'b0) begin failures++; $display("FAIL rej_n2 got=%b exp=0", got[2]); end
    endtask

    task automatic test_backpressure();
        bit to; logic [7:0] first, exp; int n = 0; bit ok = 1'b1;
        sb_q.push_back(model(4'b0101));
        send_vec(4'b0101, to);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (!out_valid) begin failures++; $display("FAIL bp_timeout got=0 exp=1"); end
        first = out_vec;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_vec !== first || in_ready !== 1'b0) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_hold got=%h exp=%h", out_vec, first); end
        exp = sb_q.pop_front();
        checks++; if (first !== exp) begin failures++; $display("FAIL bp_vec got=%h exp=%h", first, exp); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        bit to; logic [7:0] got, exp;
        send_vec(4'b1111, to);
        repeat (4) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mrst_pre_busy got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_vec !== 8'h00) begin failures++; $display("FAIL mrst_out_vec got=%h exp=00", out_vec); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) m_cfg[k] = '0;
        sb_q.push_back(model(4'b1111));
        send_vec(4'b1111, to);
        collect_vec(got, to);
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL mrst_cfg_model got=%h exp=%h", got, exp); end
        checks++; if (got !== 8'hFF) begin failures++; $display("FAIL mrst_cfg_zero got=%h exp=ff", got); end
    endtask

    task automatic test_simul_write();
        bit to; logic [7:0] got, exp;
        @(negedge clk);
        m_cfg[5] = mk_word(6'd0, 3'd0, 3'b111);
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = m_cfg[5];
        in_valid = 1'b1; in_vec = 4'b1111;
        sb_q.push_back(model(4'b1111));
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        collect_vec(got, to);
        checks++; if (to) begin failures++; $display("FAIL simul_timeout got=1 exp=0"); end
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL simul_vec got=%h exp=%h", got, exp); end
        checks++; if (got[5] !== 1'b0) begin failures++; $display("FAIL simul_n5 got=%b exp=0", got[5]); end
    endtask

    task automatic test_addr_range();
        int n = 0;
        @(negedge clk); b_cfg_we = 1'b1; b_cfg_addr = 3'd6; b_cfg_data = mk_word(6'd0, 3'd0, 3'b100);
        @(negedge clk); b_cfg_we = 1'b0;
        checks++; if (b_cfg_err !== 1'b1) begin failures++; $display("FAIL range_a6 got=%b exp=1", b_cfg_err); end
        b_cfg_we = 1'b1; b_cfg_addr = 3'd7;
        @(negedge clk); b_cfg_we = 1'b0;
        checks++; if (b_cfg_err !== 1'b1) begin failures++; $display("FAIL range_a7 got=%b exp=1", b_cfg_err); end
        b_cfg_we = 1'b1; b_cfg_addr = 3'd1;
        @(negedge clk); b_cfg_we = 1'b0;
        checks++; if (b_cfg_err !== 1'b0) begin failures++; $display("FAIL range_a1 got=%b exp=0", b_cfg_err); end
        b_in_valid = 1'b1; b_in_vec = 4'b1111;
        @(negedge clk); b_in_valid = 1'b0;
        while (!b_out_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (b_out_vec !== 6'h3D || !b_out_valid) begin failures++; $display("FAIL range_vec got=%h exp=3d", b_out_vec); end
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        b_cfg_we = 1'b0; b_cfg_addr = '0; b_cfg_data = '0;
        b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b0;
        for (int k = 0; k < 8; k++) m_cfg[k] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_latency_zero_cfg();
        test_neuron3();
        test_random();
        test_cfg_reject();
        test_backpressure();
        test_reset_mid_run();
        test_simul_write();
        test_addr_range();
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
